// File: rtl/bld_match_ctrl.sv
// bld_match_ctrl: round-robin arbiter sequencing one shared ABO phenotype decode, donor then recipient.
module bld_match_ctrl #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] pair,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              vld,
  output logic [1:0]        id,
  output logic [2:0]        dnr_pheno,
  output logic [2:0]        rcp_pheno,
  output logic              compat,
  output logic              err,
  output logic [7:0]        err_cnt
);
  typedef enum logic [1:0] {IDLE, DNR, RCP} state_t;
  state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d, id_q, id_d, sel;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [7:0] pair_q, pair_d, err_cnt_q, err_cnt_d;
  logic [2:0] dnr_st_q, dnr_st_d, dnr_pheno_q, dnr_pheno_d, rcp_pheno_q, rcp_pheno_d, rcp_dec;
  logic found, busy_q, busy_d, vld_q, vld_d, compat_q, compat_d, err_q, err_d, err_w;

  function automatic logic [2:0] decode(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'd3 || b == 2'd3) return 3'd7;
    if (a == b) return (a == 2'd2) ? 3'd3 : {1'b0, a};
    if (a == 2'd2) return {1'b0, b};
    if (b == 2'd2) return {1'b0, a};
    return 3'd2;
  endfunction

  // Scan from the highest offset down so the nearest requester to the pointer wins.
  always_comb begin
    sel = '0;
    found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[ptr_q + 2'(k)]) begin
        sel = ptr_q + 2'(k);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = (state_q == IDLE) ? (found ? DNR : IDLE) : (state_q == DNR) ? RCP : IDLE;
  end

  always_comb begin
    rcp_dec = decode(pair_q[3:2], pair_q[1:0]);
    err_w = (dnr_st_q == 3'd7) || (rcp_dec == 3'd7);
    gnt_d = '0;
    vld_d = 1'b0;
    busy_d = (state_d != IDLE);
    ptr_d = ptr_q;
    id_d = id_q;
    pair_d = pair_q;
    dnr_st_d = dnr_st_q;
    dnr_pheno_d = dnr_pheno_q;
    rcp_pheno_d = rcp_pheno_q;
    compat_d = compat_q;
    err_d = err_q;
    err_cnt_d = err_cnt_q;
    if (state_q == IDLE && found) begin
      gnt_d = NREQ'(1) << sel;
      id_d = sel;
      ptr_d = sel + 2'd1;
      pair_d = pair[8*sel +: 8];
    end
    if (state_q == DNR) dnr_st_d = decode(pair_q[7:6], pair_q[5:4]);
    if (state_q == RCP) begin
      vld_d = 1'b1;
      dnr_pheno_d = dnr_st_q;
      rcp_pheno_d = rcp_dec;
      err_d = err_w;
      compat_d = !err_w && (dnr_st_q == 3'd3 || rcp_dec == 3'd2 || dnr_st_q == rcp_dec);
      err_cnt_d = (err_w && err_cnt_q != 8'hff) ? err_cnt_q + 8'd1 : err_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      gnt_q <= '0;
      busy_q <= 1'b0;
      vld_q <= 1'b0;
      id_q <= '0;
      pair_q <= '0;
      dnr_st_q <= '0;
      dnr_pheno_q <= '0;
      rcp_pheno_q <= '0;
      compat_q <= 1'b0;
      err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      busy_q <= busy_d;
      vld_q <= vld_d;
      id_q <= id_d;
      pair_q <= pair_d;
      dnr_st_q <= dnr_st_d;
      dnr_pheno_q <= dnr_pheno_d;
      rcp_pheno_q <= rcp_pheno_d;
      compat_q <= compat_d;
      err_q <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign gnt = gnt_q;
  assign busy = busy_q;
  assign vld = vld_q;
  assign id = id_q;
  assign dnr_pheno = dnr_pheno_q;
  assign rcp_pheno = rcp_pheno_q;
  assign compat = compat_q;
  assign err = err_q;
  assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_bld_match_ctrl.sv
// tb_bld_match_ctrl: directed and randomized checks against an antigen-set reference model.
module tb_bld_match_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] req = '0, gnt;
  logic [31:0] pair = '0;
  logic busy, vld, compat, err;
  logic [1:0] id;
  logic [2:0] dnr_pheno, rcp_pheno;
  logic [7:0] err_cnt;
  int n_chk = 0, n_fail = 0;
  int cyc, due, next_ok, m_ptr, hold_all;
  int e_id, e_dnr, e_rcp, e_compat, e_err, e_cnt;
  int q_dnr, q_rcp, q_compat, q_err;
  logic [3:0] exp_gnt;
  int exp_vld;

  bld_match_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req(req), .pair(pair), .gnt(gnt), .busy(busy), .vld(vld),
    .id(id), .dnr_pheno(dnr_pheno), .rcp_pheno(rcp_pheno), .compat(compat), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Alleles map to antigen sets: A={A}, B={B}, O={}.
  function automatic int ag(input int a);
    return a == 0 ? 1 : a == 1 ? 2 : 0;
  endfunction

  function automatic int pheno(input int m, input int f);
    int s;
    if (m == 3 || f == 3) return 7;
    s = ag(m) | ag(f);
    return s == 1 ? 0 : s == 2 ? 1 : s == 3 ? 2 : 3;
  endfunction

  function automatic logic [7:0] mk(input int dm, input int df, input int rm, input int rf);
    return {2'(dm), 2'(df), 2'(rm), 2'(rf)};
  endfunction

  task automatic model_reset();
    cyc = 0; due = -1; next_ok = 0; m_ptr = 0;
    e_id = 0; e_dnr = 0; e_rcp = 0; e_compat = 0; e_err = 0; e_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_gnt"}, gnt, exp_gnt);
    check({tag, "_vld"}, vld, exp_vld);
    check({tag, "_busy"}, busy, cyc < due);
    check({tag, "_id"}, id, e_id);
    check({tag, "_dnr"}, dnr_pheno, e_dnr);
    check({tag, "_rcp"}, rcp_pheno, e_rcp);
    check({tag, "_compat"}, compat, e_compat);
    check({tag, "_err"}, err, e_err);
    check({tag, "_errcnt"}, err_cnt, e_cnt);
  endtask

  task automatic cycle();
    int sel, dm, df, rm, rf;
    logic [7:0] p;
    @(posedge clk);
    cyc++;
    exp_gnt = '0;
    exp_vld = 0;
    if (cyc == due) begin
      exp_vld = 1;
      e_dnr = q_dnr; e_rcp = q_rcp; e_compat = q_compat; e_err = q_err;
      if (q_err != 0 && e_cnt < 255) e_cnt++;
    end
    if (cyc >= next_ok && req != 0) begin
      sel = -1;
      for (int k = 0; k < 4; k++)
        if (sel < 0 && req[(m_ptr + k) % 4]) sel = (m_ptr + k) % 4;
      exp_gnt = 4'(1 << sel);
      e_id = sel;
      m_ptr = (sel + 1) % 4;
      p = pair[8*sel +: 8];
      dm = p[7:6]; df = p[5:4]; rm = p[3:2]; rf = p[1:0];
      q_dnr = pheno(dm, df);
      q_rcp = pheno(rm, rf);
      q_err = (q_dnr == 7 || q_rcp == 7) ? 1 : 0;
      q_compat = (q_err == 0 && ((ag(dm) | ag(df)) & ~(ag(rm) | ag(rf))) == 0) ? 1 : 0;
      due = cyc + 2;
      next_ok = cyc + 3;
    end
    #1;
    check_all("cyc");
    @(negedge clk);
    if (hold_all == 0) req = req & ~exp_gnt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    #1;
    model_reset();
    exp_gnt = '0;
    exp_vld = 0;
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    hold_all = 0;
    model_reset();
    do_reset();
    // Donor OO to recipient AB.
    pair[7:0] = mk(2, 2, 0, 1);
    req = 4'b0001;
    repeat (4) cycle();
    check("t1_dnr", dnr_pheno, 3);
    check("t1_rcp", rcp_pheno, 2);
    check("t1_compat", compat, 1);
    // Requester 2, donor BO to recipient AA.
    pair[23:16] = mk(1, 2, 0, 0);
    req = 4'b0100;
    repeat (4) cycle();
    check("t2_id", id, 2);
    check("t2_dnr", dnr_pheno, 1);
    check("t2_compat", compat, 0);
    // All requesters held continuously from a fresh pointer.
    do_reset();
    for (int i = 0; i < 4; i++) pair[8*i +: 8] = mk(i % 3, 2, 2 - i % 3, i % 2);
    hold_all = 1;
    req = 4'b1111;
    repeat (15) cycle();
    check("rr_last_id", id, 0);
    hold_all = 0;
    req = '0;
    repeat (3) cycle();
    // Illegal donor allele, repeated past saturation.
    pair[7:0] = mk(0, 3, 0, 0);
    for (int n = 0; n < 300; n++) begin
      req = 4'b0001;
      repeat (3) cycle();
    end
    check("sat_dnr", dnr_pheno, 7);
    check("sat_err", err, 1);
    check("sat_cnt", err_cnt, 255);
    // Abort during RCP: grant requester 0, reset, then pointer must restart at 0.
    pair[7:0] = mk(2, 2, 0, 0);
    pair[15:8] = mk(0, 0, 0, 0);
    req = 4'b0001;
    repeat (2) cycle();
    do_reset();
    repeat (3) cycle();
    req = 4'b0011;
    cycle();
    check("post_rst_gnt", gnt, 1);
    repeat (6) cycle();
    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++)
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          pair[8*i +: 8] = 8'($urandom);
          req[i] = 1'b1;
        end
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
